// File: rtl/cpu_debug_ocimem_ctrl.sv
// ============================================================================
// Module      : cpu_debug_ocimem_ctrl
// Description : Sysclk-side debug RAM controller shared between JTAG and CPU.
//               JTAG accesses always win; the CPU is stalled via waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DATA = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_mon_areg;
    logic                r_jrd_pend;
    logic                r_rd_reg_sel;
    logic [31:0]         r_ram_q;
    logic [31:0]         r_mem [DEPTH];

    logic                w_sel_b;
    logic                w_sel_a;
    logic                w_sel_na;
    logic                w_jtag_any;
    logic                w_jtag_rd;
    logic [ADDR_W-1:0]   w_jdo_addr;
    logic [ADDR_W-1:0]   w_jtag_addr;
    logic                w_cpu_req;
    logic                w_cpu_grant;
    logic                w_cpu_reg;
    logic                w_cpu_reg_wr;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [31:0]         w_ram_wdata;
    logic                w_unused_ok;

    // Strobe priority resolves any overlap: ocimem_b > action_a > no_action_a
    assign w_sel_b     = take_action_ocimem_b;
    assign w_sel_a     = !take_action_ocimem_b && take_action_ocimem_a;
    assign w_sel_na    = !take_action_ocimem_b && !take_action_ocimem_a && take_no_action_ocimem_a;
    assign w_jtag_any  = w_sel_b || w_sel_a || w_sel_na;
    assign w_jdo_addr  = jdo[ADDR_W+16:17];
    assign w_jtag_rd   = (w_sel_a && jdo[35]) || w_sel_na;
    assign w_jtag_addr = w_sel_a ? w_jdo_addr : r_mon_areg;

    assign w_cpu_req    = cpu_read || cpu_write;
    assign w_cpu_grant  = (r_state == ST_IDLE) && w_cpu_req && !w_jtag_any;
    assign w_cpu_reg    = cpu_addr[ADDR_W];
    assign w_cpu_reg_wr = w_cpu_grant && !cpu_read && cpu_write && w_cpu_reg;

    assign w_unused_ok  = &{1'b0, jdo[37:36], jdo[2:0]};

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = cpu_addr[ADDR_W-1:0];
        w_ram_wdata = cpu_wdata;
        if (w_jtag_any) begin
            w_ram_addr  = w_jtag_addr;
            w_ram_wdata = jdo[34:3];
            w_ram_we    = w_sel_b && reset_n;
            w_ram_re    = w_jtag_rd;
        end else if (w_cpu_grant && !w_cpu_reg) begin
            w_ram_re    = cpu_read;
            w_ram_we    = !cpu_read && cpu_write && reset_n;
        end
    end

    // Single-port RAM, read-first, registered output; contents survive reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        cpu_waitrequest = 1'b0;
        cpu_rdata       = 32'h0;
        case (r_state)
            ST_IDLE: begin
                cpu_waitrequest = w_cpu_req;
                if (w_cpu_grant) begin
                    if (cpu_read) begin
                        w_state_nxt = ST_RD_DATA;
                    end else begin
                        cpu_waitrequest = 1'b0;
                    end
                end
            end
            ST_RD_DATA: begin
                cpu_rdata   = r_rd_reg_sel ? {30'h0, monitor_error, monitor_ready} : r_ram_q;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_mon_areg    <= '0;
            r_jrd_pend    <= 1'b0;
            r_rd_reg_sel  <= 1'b0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_jrd_pend <= w_jtag_rd;
            if (r_jrd_pend) begin
                MonDReg <= r_ram_q;
            end

            if (w_sel_b || w_sel_na) begin
                r_mon_areg <= r_mon_areg + 1'b1;
            end else if (w_sel_a) begin
                r_mon_areg <= jdo[35] ? (w_jdo_addr + 1'b1) : w_jdo_addr;
            end

            if (w_cpu_grant && cpu_read) begin
                r_rd_reg_sel <= w_cpu_reg;
            end

            // JTAG clear takes precedence over a CPU set
            if (w_sel_a && jdo[25]) begin
                monitor_ready <= 1'b0;
            end else if (w_cpu_reg_wr) begin
                monitor_ready <= cpu_wdata[0] | monitor_ready;
            end
            if (w_cpu_reg_wr) begin
                monitor_error <= cpu_wdata[1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// ============================================================================
// Module      : tb_cpu_debug_ocimem_ctrl
// Description : Scoreboard bench for cpu_debug_ocimem_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_debug_ocimem_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam logic [ADDR_W:0] C_REG = 9'h100;

    logic              clk;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W:0]   cpu_addr;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    int errors = 0;
    int checks = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] jtag_q[$];
    logic        jp0, jp1;
    logic        tb_jrd;

    cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_addr                (cpu_addr),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_wdata               (cpu_wdata),
        .cpu_rdata               (cpu_rdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A JTAG read issued in cycle N shows up on MonDReg in cycle N+2
    assign tb_jrd = !take_action_ocimem_b &&
                    ((take_action_ocimem_a && jdo[35]) || take_no_action_ocimem_a);

    always @(posedge clk) begin
        if (!reset_n) begin
            jp0 <= 1'b0;
            jp1 <= 1'b0;
        end else begin
            jp0 <= tb_jrd;
            jp1 <= jp0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents read data
    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_read && !cpu_waitrequest) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_rdata_unexpected", cpu_rdata, 32'hxxxx_xxxx);
                end else begin
                    check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end
            end
            if (jp1) begin
                if (jtag_q.size() == 0) begin
                    check("MonDReg_unexpected", MonDReg, 32'hxxxx_xxxx);
                end else begin
                    check("MonDReg", MonDReg, jtag_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_a(input logic [ADDR_W-1:0] addr, input logic rd, input logic clr,
                          input logic [31:0] exp);
        jdo = '0;
        jdo[ADDR_W+16:17] = addr;
        jdo[35] = rd;
        jdo[25] = clr;
        take_action_ocimem_a = 1'b1;
        if (rd) jtag_q.push_back(exp);
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_na(input logic [31:0] exp);
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        jtag_q.push_back(exp);
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_wr(input logic [ADDR_W:0] addr, input logic [31:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = 1'b1;
        @(negedge clk);
        check("wr_waitrequest", {31'h0, cpu_waitrequest}, 32'h0);
        step();
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [ADDR_W:0] addr, input logic [31:0] exp);
        cpu_addr = addr;
        cpu_read = 1'b1;
        cpu_q.push_back(exp);
        @(negedge clk);
        check("rd_wait_grant", {31'h0, cpu_waitrequest}, 32'h1);
        step();
        @(negedge clk);
        check("rd_wait_data", {31'h0, cpu_waitrequest}, 32'h0);
        step();
        cpu_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        cpu_addr = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_ready", {31'h0, monitor_ready}, 32'h0);
        check("rst_error", {31'h0, monitor_error}, 32'h0);
        check("rst_waitreq", {31'h0, cpu_waitrequest}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        reset_n = 1'b1;
        step();

        // JTAG write then read-back with auto-increment
        jtag_a(8'd5, 1'b0, 1'b0, 32'h0);
        jtag_b(32'hDEADBEEF);
        jtag_b(32'h12345678);
        jtag_a(8'd5, 1'b1, 1'b0, 32'hDEADBEEF);
        jtag_na(32'h12345678);
        repeat (3) step();

        // Address wrap from DEPTH-1 to 0
        jtag_a(8'(DEPTH - 1), 1'b0, 1'b0, 32'h0);
        jtag_b(32'hA1A1A1A1);
        jtag_b(32'hB2B2B2B2);
        jtag_a(8'(DEPTH - 1), 1'b1, 1'b0, 32'hA1A1A1A1);
        jtag_na(32'hB2B2B2B2);
        repeat (3) step();
        cpu_rd(9'd0, 32'hB2B2B2B2);

        // CPU write then read of word 7
        cpu_wr(9'd7, 32'hCAFEF00D);
        cpu_rd(9'd7, 32'hCAFEF00D);
        cpu_rd(9'd6, 32'h12345678);

        // CPU read colliding with a JTAG write to the same word
        jtag_a(8'd5, 1'b0, 1'b0, 32'h0);
        cpu_addr = 9'd5;
        cpu_read = 1'b1;
        jdo = '0;
        jdo[34:3] = 32'h55AA55AA;
        take_action_ocimem_b = 1'b1;
        cpu_q.push_back(32'h55AA55AA);
        @(negedge clk);
        check("coll_wait0", {31'h0, cpu_waitrequest}, 32'h1);
        step();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        check("coll_wait1", {31'h0, cpu_waitrequest}, 32'h1);
        step();
        @(negedge clk);
        check("coll_wait2", {31'h0, cpu_waitrequest}, 32'h0);
        step();
        cpu_read = 1'b0;

        // Status register handshake
        cpu_wr(C_REG, 32'h1);
        @(negedge clk);
        check("ready_set", {31'h0, monitor_ready}, 32'h1);
        step();
        cpu_wr(C_REG, 32'h2);
        @(negedge clk);
        check("error_set", {31'h0, monitor_error}, 32'h1);
        check("ready_kept", {31'h0, monitor_ready}, 32'h1);
        step();
        cpu_rd(C_REG, 32'h3);
        cpu_addr  = C_REG;
        cpu_wdata = 32'h1;
        cpu_write = 1'b1;
        jdo = '0;
        jdo[25] = 1'b1;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        check("clr_coll_wait", {31'h0, cpu_waitrequest}, 32'h1);
        step();
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("clear_wins", {31'h0, monitor_ready}, 32'h0);
        step();
        cpu_write = 1'b0;

        // Reset while a CPU read is outstanding
        cpu_addr = 9'd7;
        cpu_read = 1'b1;
        @(negedge clk);
        check("rstrd_grant", {31'h0, cpu_waitrequest}, 32'h1);
        step();
        reset_n = 1'b0;
        step();
        cpu_read = 1'b0;
        @(negedge clk);
        check("rstrd_waitreq", {31'h0, cpu_waitrequest}, 32'h0);
        check("rstrd_rdata", cpu_rdata, 32'h0);
        check("rstrd_MonDReg", MonDReg, 32'h0);
        check("rstrd_ready", {31'h0, monitor_ready}, 32'h0);
        check("rstrd_error", {31'h0, monitor_error}, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        cpu_rd(9'd7, 32'hCAFEF00D);

        repeat (3) step();
        check("queues_drained", cpu_q.size() + jtag_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
